// File: rtl/fb_pkg.sv
// Shared framebuffer defaults and the address-width helper.
package fb_pkg;
   localparam int H_RES_DEF = 640;
   localparam int V_RES_DEF = 480;
   localparam int PIX_W_DEF = 4;
   localparam int IN_W_DEF  = 8;

   // Bits needed to address 'value' entries; never less than 1.
   function automatic int clog2(input int value);
      int r;
      r = 0;
      while ((1 << r) < value) r++;
      return (r < 1) ? 1 : r;
   endfunction
endpackage

// File: rtl/framebuffer_ram_if.sv
// Pixel write, read and status bundle between a frame producer/display and framebuffer_ram.
interface framebuffer_ram_if #(
   parameter int ADR_W = fb_pkg::clog2(fb_pkg::H_RES_DEF * fb_pkg::V_RES_DEF),
   parameter int IN_W  = fb_pkg::IN_W_DEF,
   parameter int PIX_W = fb_pkg::PIX_W_DEF
);
   logic             we_i;
   logic             auto_i;
   logic [ADR_W-1:0] adr_i;
   logic [IN_W-1:0]  dat_i;
   logic             clr_i;
   logic             rd_en_i;
   logic [ADR_W-1:0] rd_adr_i;
   logic             swap_i;
   logic [PIX_W-1:0] rd_dat_o;
   logic             rd_vld_o;
   logic [ADR_W-1:0] wr_ptr_o;
   logic             frame_done_o;
   logic             bank_o;

   modport slave (
      input  we_i, auto_i, adr_i, dat_i, clr_i, rd_en_i, rd_adr_i, swap_i,
      output rd_dat_o, rd_vld_o, wr_ptr_o, frame_done_o, bank_o
   );
   modport master (
      output we_i, auto_i, adr_i, dat_i, clr_i, rd_en_i, rd_adr_i, swap_i,
      input  rd_dat_o, rd_vld_o, wr_ptr_o, frame_done_o, bank_o
   );
endinterface

// File: rtl/fb_bank.sv
// One pixel bank: single write port, synchronous read port (read-before-write, 1 cycle).
// Out-of-range reads return 0; the read register holds when no read is issued.
module fb_bank #(
   parameter int DEPTH = 307200,
   parameter int ADR_W = 19,
   parameter int PIX_W = 4
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             we_i,
   input  logic [ADR_W-1:0] wadr_i,
   input  logic [PIX_W-1:0] wdat_i,
   input  logic             rd_en_i,
   input  logic [ADR_W-1:0] radr_i,
   output logic [PIX_W-1:0] rdat_o
);
   logic [PIX_W-1:0] mem [DEPTH];

   // Storage is never reset so a mid-frame reset keeps the picture.
   always_ff @(posedge clk_i) begin
      if (we_i) mem[wadr_i] <= wdat_i;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i)
         rdat_o <= '0;
      else if (rd_en_i)
         rdat_o <= (int'(radr_i) < DEPTH) ? mem[radr_i] : '0;
   end
endmodule

// File: rtl/framebuffer_ram.sv
// Frame store with auto-increment write pointer, frame-done flag and 1-cycle reads.
// Define FRAMEBUFFER_DOUBLE_BUFFER_EN for two banks swapped on swap request + frame done.
module framebuffer_ram
   import fb_pkg::*;
#(
   parameter int H_RES = H_RES_DEF,
   parameter int V_RES = V_RES_DEF,
   parameter int PIX_W = PIX_W_DEF,
   parameter int IN_W  = IN_W_DEF
) (
   input  logic              clk_i,
   input  logic              rst_i,
   framebuffer_ram_if.slave  bus
);
   localparam int DEPTH = H_RES * V_RES;
   localparam int ADR_W = clog2(DEPTH);

   logic [ADR_W-1:0] wr_ptr;
   logic [ADR_W-1:0] wr_adr;
   logic [PIX_W-1:0] wr_pix;
   logic             wr_ok;
   logic             frame_done;
   logic             rd_vld;
   logic             bank;
   logic             swap_fire;

   assign wr_adr = bus.auto_i ? wr_ptr : bus.adr_i;
   assign wr_pix = bus.dat_i[IN_W-1 -: PIX_W];
   assign wr_ok  = bus.we_i && !rst_i && (int'(wr_adr) < DEPTH);

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wr_ptr     <= '0;
         frame_done <= 1'b0;
         rd_vld     <= 1'b0;
      end else begin
         rd_vld <= bus.rd_en_i;
         // Swap and clear both restart the frame and win over a same-cycle write.
         if (swap_fire || bus.clr_i) begin
            wr_ptr     <= '0;
            frame_done <= 1'b0;
         end else begin
            if (bus.we_i && bus.auto_i)
               wr_ptr <= (wr_ptr == ADR_W'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
            if (wr_ok && (int'(wr_adr) == DEPTH - 1))
               frame_done <= 1'b1;
         end
      end
   end

`ifdef FRAMEBUFFER_DOUBLE_BUFFER_EN
   logic             swap_pend;
   logic             rd_sel;
   logic [PIX_W-1:0] rdat [2];

   assign swap_fire = swap_pend && frame_done;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         swap_pend <= 1'b0;
         bank      <= 1'b0;
         rd_sel    <= 1'b0;
      end else begin
         if (swap_fire) begin
            swap_pend <= 1'b0;
            bank      <= ~bank;
         end else if (bus.swap_i) begin
            swap_pend <= 1'b1;
         end
         if (bus.rd_en_i) rd_sel <= bank;
      end
   end

   // The displayed bank is read; the other one is being drawn.
   for (genvar b = 0; b < 2; b++) begin : g_bank
      fb_bank #(.DEPTH(DEPTH), .ADR_W(ADR_W), .PIX_W(PIX_W)) u_bank (
         .clk_i   (clk_i),
         .rst_i   (rst_i),
         .we_i    (wr_ok && (bank != 1'(b))),
         .wadr_i  (wr_adr),
         .wdat_i  (wr_pix),
         .rd_en_i (bus.rd_en_i && (bank == 1'(b))),
         .radr_i  (bus.rd_adr_i),
         .rdat_o  (rdat[b])
      );
   end

   assign bus.rd_dat_o = rd_sel ? rdat[1] : rdat[0];
`else
   logic unused_swap;

   assign unused_swap = bus.swap_i;
   assign swap_fire   = 1'b0;
   assign bank        = 1'b0;

   fb_bank #(.DEPTH(DEPTH), .ADR_W(ADR_W), .PIX_W(PIX_W)) u_bank (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .we_i    (wr_ok),
      .wadr_i  (wr_adr),
      .wdat_i  (wr_pix),
      .rd_en_i (bus.rd_en_i),
      .radr_i  (bus.rd_adr_i),
      .rdat_o  (bus.rd_dat_o)
   );
`endif

   assign bus.rd_vld_o     = rd_vld;
   assign bus.wr_ptr_o     = wr_ptr;
   assign bus.frame_done_o = frame_done;
   assign bus.bank_o       = bank;
endmodule

// File: tb/tb_framebuffer_ram.sv
// Bench for framebuffer_ram on a 10x10 frame (depth 100, 7-bit addresses so out-of-range is reachable).
// Reads are scoreboarded against a behavioural frame model; status outputs are checked every cycle.
module tb_framebuffer_ram;
   localparam int H = 10, V = 10, DEPTH = 100, AW = 7, IW = 8, PW = 4;
`ifdef FRAMEBUFFER_DOUBLE_BUFFER_EN
   localparam bit DB = 1'b1;
`else
   localparam bit DB = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   framebuffer_ram_if #(.ADR_W(AW), .IN_W(IW), .PIX_W(PW)) bus();

   framebuffer_ram #(.H_RES(H), .V_RES(V), .PIX_W(PW), .IN_W(IW)) dut (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus)
   );

   int mem_m [2][DEPTH];
   int ptr_m = 0, done_m = 0, pend_m = 0, bank_m = 0, vld_m = 0, last_m = 0;
   int q[$];
   int compared = 0, mismatched = 0;
   bit mon_en = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   // Frame model: what one clock edge does to the stored picture and status.
   task automatic model_update();
      int rb, wb, eff;
      bit wrote, fire;
      if (rst) begin
         ptr_m = 0; done_m = 0; pend_m = 0; bank_m = 0; vld_m = 0; last_m = 0;
         return;
      end
      rb = DB ? bank_m : 0;
      wb = DB ? 1 - bank_m : 0;
      vld_m = bus.rd_en_i;
      if (bus.rd_en_i) begin
         last_m = (int'(bus.rd_adr_i) < DEPTH) ? mem_m[rb][bus.rd_adr_i] : 0;
         q.push_back(last_m);
      end
      eff   = bus.auto_i ? ptr_m : int'(bus.adr_i);
      wrote = bus.we_i && (eff < DEPTH);
      if (wrote) mem_m[wb][eff] = int'(bus.dat_i) >> (IW - PW);
      fire = DB && (pend_m != 0) && (done_m != 0);
      if (fire || bus.clr_i) begin
         ptr_m = 0; done_m = 0;
      end else begin
         if (bus.we_i && bus.auto_i) ptr_m = (ptr_m + 1) % DEPTH;
         if (wrote && eff == DEPTH - 1) done_m = 1;
      end
      if (fire) begin
         pend_m = 0; bank_m = 1 - bank_m;
      end else if (DB && bus.swap_i) begin
         pend_m = 1;
      end
   endtask

   task automatic step(input bit r, input bit we, input bit au, input int adr, input int dat,
                       input bit clr, input bit rd, input int radr, input bit sw);
      @(negedge clk);
      rst          = r;
      bus.we_i     = we;
      bus.auto_i   = au;
      bus.adr_i    = AW'(adr);
      bus.dat_i    = IW'(dat);
      bus.clr_i    = clr;
      bus.rd_en_i  = rd;
      bus.rd_adr_i = AW'(radr);
      bus.swap_i   = sw;
      @(posedge clk);
      #1 model_update();
   endtask

   task automatic idle(); step(0, 0, 0, 0, 0, 0, 0, 0, 0); endtask
   task automatic rd(input int a); step(0, 0, 0, 0, 0, 0, 1, a, 0); endtask

   always @(negedge clk) begin : mon
      int e;
      if (mon_en) begin
         chk("rd_vld", 32'(bus.rd_vld_o), 32'(vld_m));
         if (bus.rd_vld_o === 1'b1) begin
            if (q.size() == 0) begin
               compared++;
               mismatched++;
               $display("FAIL rd_unexpected at %0t: got valid read expected none", $time);
            end else begin
               e = q.pop_front();
               chk("rd_dat", 32'(bus.rd_dat_o), 32'(e));
            end
         end else begin
            chk("rd_hold", 32'(bus.rd_dat_o), 32'(last_m));
         end
         chk("wr_ptr", 32'(bus.wr_ptr_o), 32'(ptr_m));
         chk("frame_done", 32'(bus.frame_done_o), 32'(done_m));
         chk("bank", 32'(bus.bank_o), 32'(bank_m));
      end
   end

   initial begin
      bus.we_i = 0; bus.auto_i = 0; bus.adr_i = '0; bus.dat_i = '0; bus.clr_i = 0;
      bus.rd_en_i = 0; bus.rd_adr_i = '0; bus.swap_i = 0;
      step(1, 0, 0, 0, 0, 0, 0, 0, 0);
      mon_en = 1'b1;
      step(1, 0, 0, 0, 0, 0, 1, 3, 0);

      // Full frame of A5 via the auto pointer: wrap and frame_done.
      for (int i = 0; i < DEPTH; i++) step(0, 1, 1, 0, 8'hA5, 0, 0, 0, 0);
      rd(DEPTH - 1);
      idle();
      if (DB) begin
         step(0, 0, 0, 0, 0, 0, 0, 0, 1);
         idle();
         idle();
         for (int i = 0; i < DEPTH; i++) step(0, 1, 1, 0, 8'hA5, 0, 0, 0, 0);
         idle();
      end

      // Explicit write then read; same-cycle read/write returns old data.
      step(0, 1, 0, 50, 8'h3C, 0, 0, 0, 0);
      rd(50);
      idle();
      step(0, 1, 0, 51, 8'hF0, 0, 1, 51, 0);
      rd(51);

      // Out-of-range write and reads.
      step(0, 1, 0, DEPTH, 8'hFF, 0, 0, 0, 0);
      rd(DEPTH);
      rd(120);
      rd(DEPTH - 1);

      // Clear coinciding with a write to the last pixel.
      for (int i = 0; i < 4; i++) step(0, 1, 1, 0, 8'h11, 0, 0, 0, 0);
      step(0, 1, 0, DEPTH - 1, 8'h7E, 1, 0, 0, 0);
      rd(DEPTH - 1);
      idle();

      // Reset mid-frame keeps pixel data.
      for (int i = 0; i < 50; i++) step(0, 1, 1, 0, i * 5, 0, 0, 0, 0);
      step(1, 1, 1, 0, 8'hFF, 0, 1, 2, 1);
      rd(2);
      rd(49);
      rd(50);
      idle();

      // Randomized traffic.
      for (int i = 0; i < 600; i++) begin
         step($urandom_range(0, 99) == 0, $urandom_range(0, 1), $urandom_range(0, 2) != 0,
              $urandom_range(0, 127), $urandom_range(0, 255), $urandom_range(0, 24) == 0,
              $urandom_range(0, 1), $urandom_range(0, 127), $urandom_range(0, 29) == 0);
      end

      idle();
      idle();
      idle();
      chk("queue_empty", 32'(q.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule

// File: doc/framebuffer_ram.md
FRAMEBUFFER_RAM -- requirements
Module: framebuffer_ram

Interface
REQ-001 SHALL have parameter H_RES, default 640, horizontal pixels per line.
REQ-002 SHALL have parameter V_RES, default 480, lines per frame.
REQ-003 SHALL have parameter PIX_W, default 4, stored bits per pixel.
REQ-004 SHALL have parameter IN_W, default 8, write data width (IN_W >= PIX_W).
REQ-005 SHALL derive DEPTH = H_RES*V_RES and ADR_W = clog2(DEPTH).
REQ-006 SHALL have port clk_i  input  1  single clock, all logic on rising edge.
REQ-007 SHALL have port rst_i  input  1  reset, synchronous, active-high.
REQ-008 SHALL have port we_i  input  1  write strobe, one pixel per cycle.
REQ-009 SHALL have port auto_i  input  1  1 = write to internal pointer, ignore adr_i.
REQ-010 SHALL have port adr_i  input  ADR_W  explicit write address.
REQ-011 SHALL have port dat_i  input  IN_W  write data.
REQ-012 SHALL have port clr_i  input  1  restart frame: pointer to 0, clear frame_done_o.
REQ-013 SHALL have port rd_en_i  input  1  read request.
REQ-014 SHALL have port rd_adr_i  input  ADR_W  read address.
REQ-015 SHALL have port rd_dat_o  output  PIX_W  read pixel.
REQ-016 SHALL have port rd_vld_o  output  1  rd_dat_o valid this cycle.
REQ-017 SHALL have port wr_ptr_o  output  ADR_W  current auto-write pointer.
REQ-018 SHALL have port frame_done_o  output  1  last pixel of frame written.
REQ-019 SHALL have ports swap_i input 1 (buffer swap request) and bank_o output 1 (bank currently displayed).

Function
REQ-020 SHALL store dat_i[IN_W-1 -: PIX_W] (MSBs) on a we_i cycle; address = wr_ptr if auto_i else adr_i.
REQ-021 SHALL ignore writes with effective address >= DEPTH (no store, no flag change).
REQ-022 SHALL increment wr_ptr on each auto_i write; DEPTH-1 wraps to 0.
REQ-023 SHALL set frame_done_o the cycle after any accepted write to address DEPTH-1, sticky until clr_i, swap or reset.
REQ-024 SHALL give clr_i priority over a same-cycle write: write stored, pointer becomes 0, frame_done_o becomes 0.
REQ-025 SHALL have read latency 1: rd_dat_o and rd_vld_o=1 on the cycle after rd_en_i; rd_vld_o=0 otherwise; rd_dat_o holds its last value.
REQ-026 SHALL return 0 for reads with rd_adr_i >= DEPTH (rd_vld_o still asserted).
REQ-027 SHALL return old data when a read and a write hit the same address in one cycle (read-before-write).

Reset
REQ-028 SHALL on rst_i force wr_ptr_o=0, frame_done_o=0, rd_dat_o=0, rd_vld_o=0, bank_o=0, swap pending=0; rst_i overrides all other inputs.
REQ-029 SHALL NOT clear pixel memory on reset; a reset mid-frame discards progress only.

Configuration
REQ-030 SHALL support macro FRAMEBUFFER_DOUBLE_BUFFER_EN.
REQ-031 SHALL, with the macro defined, hold two banks; writes target bank ~bank_o, reads bank bank_o.
REQ-032 SHALL, with the macro, latch swap_i into a pending flag; when pending and frame_done_o are both 1, the next edge toggles bank_o, clears frame_done_o, pending and wr_ptr.
REQ-033 SHALL, with the macro, treat swap_i coinciding with clr_i as pending (clr_i applied, swap waits for next frame_done_o).
REQ-034 SHALL, without the macro, hold one bank, ignore swap_i and tie bank_o to 0.

Structure
REQ-035 SHALL place H_RES/V_RES/PIX_W defaults and a clog2 function in shared package fb_pkg.
REQ-036 SHALL implement storage as sub-module fb_bank (1 write port, 1 synchronous read port, DEPTH x PIX_W), instantiated once or twice.

Verification
REQ-037 SHALL cover: reset, auto_i=1, 307200 writes of 8'hA5 -> wr_ptr_o wraps to 0, frame_done_o=1 one cycle after last write, read addr 307199 -> 4'hA.
REQ-038 SHALL cover: explicit write adr 1000 data 8'h3C, read adr 1000 -> rd_dat_o=4'h3, rd_vld_o=1 exactly one cycle later.
REQ-039 SHALL cover: write adr 307200 -> memory and frame_done_o unchanged; read adr 307200 -> rd_dat_o=0.
REQ-040 SHALL cover: clr_i with write to 307199 same cycle -> data stored, frame_done_o=0, wr_ptr_o=0.
REQ-041 SHALL cover (macro on): swap_i mid-frame -> bank_o stays 0 until frame_done_o, then 1 next cycle, frame_done_o=0.
REQ-042 SHALL cover: rst_i asserted at pointer 5000 -> wr_ptr_o=0, rd_vld_o=0, prior pixel data still readable.
